// File: rtl/dds_sweep_ctrl_if.sv
// Sweep controller bus: configuration/handshake inputs from the system
// controller and the registered tuning word / status outputs back to it.
interface dds_sweep_ctrl_if #(
  parameter int unsigned TUNE_WIDTH  = 16,
  parameter int unsigned DWELL_WIDTH = 16
);
  logic                   start;
  logic                   abort;
  logic                   continuous;
  logic [TUNE_WIDTH-1:0]  start_word;
  logic [TUNE_WIDTH-1:0]  stop_word;
  logic [TUNE_WIDTH-1:0]  step_word;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [TUNE_WIDTH-1:0]  tuning_word;
  logic                   busy;
  logic                   done;
  logic                   step_strobe;

  // System controller side
  modport master (
    output start, abort, continuous, start_word, stop_word, step_word, dwell,
    input  tuning_word, busy, done, step_strobe
  );

  // Sweep sequencer side
  modport slave (
    input  start, abort, continuous, start_word, stop_word, step_word, dwell,
    output tuning_word, busy, done, step_strobe
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer. Steps the tuning word from start toward stop,
// holding each word for max(dwell,1) clocks, with single-shot or continuous
// repetition. Optional macro DDS_SWEEP_PINGPONG_EN makes continuous sweeps
// triangular instead of sawtooth.
module dds_sweep_ctrl #(
  parameter int unsigned TUNE_WIDTH  = 16,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input logic             clk,
  input logic             RST,
  dds_sweep_ctrl_if.slave bus
);

  typedef logic [TUNE_WIDTH-1:0]  tune_t;
  typedef logic [DWELL_WIDTH-1:0] dwell_t;

  // The STEP decision is folded into the last DWELL cycle so word changes are
  // back-to-back; no separate cycle is spent in a step state.
  typedef enum logic [0:0] {StIdle, StDwell} state_e;

  state_e state_q, state_d;
  tune_t  tune_q, tune_d;
  tune_t  target_q, target_d;   // endpoint currently being approached
  tune_t  origin_q, origin_d;   // endpoint the current leg started from
  tune_t  step_q, step_d;
  dwell_t dwell_m1_q, dwell_m1_d;
  dwell_t cnt_q, cnt_d;
  logic   up_q, up_d;
  logic   cont_q, cont_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   strobe_q, strobe_d;

  // One step toward target, clamped at target on overshoot or carry/borrow out.
  function automatic tune_t step_next(tune_t cur, tune_t target, tune_t step, logic up);
    logic [TUNE_WIDTH:0] ext;
    if (up) begin
      ext = {1'b0, cur} + {1'b0, step};
      if (ext[TUNE_WIDTH] || (ext[TUNE_WIDTH-1:0] > target)) return target;
    end else begin
      ext = {1'b0, cur} - {1'b0, step};
      if (ext[TUNE_WIDTH] || (ext[TUNE_WIDTH-1:0] < target)) return target;
    end
    return ext[TUNE_WIDTH-1:0];
  endfunction

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    tune_d     = tune_q;
    target_d   = target_q;
    origin_d   = origin_q;
    step_d     = step_q;
    dwell_m1_d = dwell_m1_q;
    cnt_d      = cnt_q;
    up_d       = up_q;
    cont_d     = cont_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    strobe_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          origin_d   = bus.start_word;
          target_d   = bus.stop_word;
          up_d       = (bus.stop_word >= bus.start_word);
          step_d     = (bus.step_word == '0) ? tune_t'(1) : bus.step_word;
          dwell_m1_d = (bus.dwell == '0) ? '0 : bus.dwell - dwell_t'(1);
          cnt_d      = (bus.dwell == '0) ? '0 : bus.dwell - dwell_t'(1);
          cont_d     = bus.continuous;
          tune_d     = bus.start_word;
          strobe_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = StDwell;
        end
      end
      StDwell: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - dwell_t'(1);
        end else if (tune_q != target_q) begin
          tune_d   = step_next(tune_q, target_q, step_q, up_q);
          strobe_d = 1'b1;
          cnt_d    = dwell_m1_q;
        end else if (!cont_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
`ifdef DDS_SWEEP_PINGPONG_EN
          // Reverse: the endpoint just dwelled is not repeated.
          target_d = origin_q;
          origin_d = target_q;
          up_d     = ~up_q;
          tune_d   = step_next(tune_q, origin_q, step_q, ~up_q);
`else
          tune_d   = origin_q;
`endif
          strobe_d = 1'b1;
          cnt_d    = dwell_m1_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      tune_q     <= '0;
      target_q   <= '0;
      origin_q   <= '0;
      step_q     <= '0;
      dwell_m1_q <= '0;
      cnt_q      <= '0;
      up_q       <= 1'b0;
      cont_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tune_q     <= tune_d;
      target_q   <= target_d;
      origin_q   <= origin_d;
      step_q     <= step_d;
      dwell_m1_q <= dwell_m1_d;
      cnt_q      <= cnt_d;
      up_q       <= up_d;
      cont_q     <= cont_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      strobe_q   <= strobe_d;
    end
  end

  assign bus.tuning_word = tune_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.step_strobe = strobe_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed vector table plus randomized sweeps
// compared cycle by cycle against a list-of-words reference model.
module tb_dds_sweep_ctrl;

  logic clk = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   leg_q[$];
  logic [15:0] last_tw = '0;

  dds_sweep_ctrl_if #(.TUNE_WIDTH(16), .DWELL_WIDTH(16)) bus_if ();

  dds_sweep_ctrl #(.TUNE_WIDTH(16), .DWELL_WIDTH(16)) u_dut (
    .clk (clk),
    .RST (RST),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic [15:0] e;
    logic [15:0] st;
    logic [15:0] dw;
    bit          cont;
    bit          abrt;
    int          n;
    int          w[8];
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] tw, input bit b, input bit sb,
                     input bit dn);
    checks++;
    if (bus_if.tuning_word !== tw || bus_if.busy !== b || bus_if.step_strobe !== sb ||
        bus_if.done !== dn) begin
      errors++;
      $display("FAIL %s: got tw=%h busy=%b stb=%b done=%b, want tw=%h busy=%b stb=%b done=%b",
               name, bus_if.tuning_word, bus_if.busy, bus_if.step_strobe, bus_if.done,
               tw, b, sb, dn);
    end
  endtask

  // Reference: the sequence of words of one leg, from s toward e, by plain arithmetic.
  function automatic void build_leg(input int s, input int e, input int st);
    int w;
    int step;
    w = s;
    step = (st == 0) ? 1 : st;
    leg_q = {};
    leg_q.push_back(w);
    while (w != e) begin
      if (e >= s) w = (w + step > e) ? e : w + step;
      else        w = (w - step < e) ? e : w - step;
      leg_q.push_back(w);
    end
  endfunction

  // Config inputs and start are noise while a sweep runs; both must be ignored.
  task automatic scramble();
    bus_if.start      = 1'($urandom_range(0, 1));
    bus_if.continuous = 1'($urandom_range(0, 1));
    bus_if.start_word = 16'($urandom);
    bus_if.stop_word  = 16'($urandom);
    bus_if.step_word  = 16'($urandom);
    bus_if.dwell      = 16'($urandom);
  endtask

  // Launch a sweep and check every cycle against exp_q. With do_abort, abort is
  // raised in the final cycle of the last expected word.
  task automatic check_sweep(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                             input logic [15:0] dw, input bit cont, input bit do_abort,
                             input bit from_done, input bit to_next);
    int d;
    int n;
    d = (dw == 0) ? 1 : int'(dw);
    n = exp_q.size();
    if (!from_done) @(negedge clk);
    bus_if.start      = 1'b1;
    bus_if.abort      = 1'b0;
    bus_if.continuous = cont;
    bus_if.start_word = s;
    bus_if.stop_word  = e;
    bus_if.step_word  = st;
    bus_if.dwell      = dw;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < d; j++) begin
        if (!(k == 0 && j == 0)) @(negedge clk);
        chk("sweep_word", 16'(exp_q[k]), 1'b1, j == 0, 1'b0);
        scramble();
        if (do_abort && k == n - 1 && j == d - 1) bus_if.abort = 1'b1;
      end
    end
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    if (do_abort) begin
      chk("abort", 16'(exp_q[n-1]), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("post_abort", 16'(exp_q[n-1]), 1'b0, 1'b0, 1'b0);
    end else begin
      chk("done", 16'(exp_q[n-1]), 1'b0, 1'b0, 1'b1);
      if (!to_next) begin
        @(negedge clk);
        chk("post_done", 16'(exp_q[n-1]), 1'b0, 1'b0, 1'b0);
      end
    end
    last_tw = 16'(exp_q[n-1]);
  endtask

  initial begin
    bus_if.start      = 1'b0;
    bus_if.abort      = 1'b0;
    bus_if.continuous = 1'b0;
    bus_if.start_word = '0;
    bus_if.stop_word  = '0;
    bus_if.step_word  = '0;
    bus_if.dwell      = '0;

    vecs[0] = '{16'd100, 16'd130, 16'd10, 16'd3, 1'b0, 1'b0, 4, '{100, 110, 120, 130, 0, 0, 0, 0}};
    vecs[1] = '{16'h0000, 16'h0019, 16'd10, 16'd1, 1'b0, 1'b0, 4, '{0, 10, 20, 25, 0, 0, 0, 0}};
    vecs[2] = '{16'hFFF0, 16'hFFFF, 16'h000C, 16'd1, 1'b0, 1'b0, 3,
                '{'hFFF0, 'hFFFC, 'hFFFF, 0, 0, 0, 0, 0}};
    vecs[3] = '{16'd50, 16'd20, 16'd15, 16'd0, 1'b0, 1'b0, 3, '{50, 35, 20, 0, 0, 0, 0, 0}};
    vecs[4] = '{16'd5, 16'd7, 16'd0, 16'd1, 1'b0, 1'b0, 3, '{5, 6, 7, 0, 0, 0, 0, 0}};
    vecs[5] = '{16'd42, 16'd42, 16'd7, 16'd2, 1'b0, 1'b0, 1, '{42, 0, 0, 0, 0, 0, 0, 0}};
    vecs[6] = '{16'd100, 16'd130, 16'd10, 16'd3, 1'b0, 1'b1, 2, '{100, 110, 0, 0, 0, 0, 0, 0}};
`ifdef DDS_SWEEP_PINGPONG_EN
    vecs[7] = '{16'd0, 16'd10, 16'd5, 16'd1, 1'b1, 1'b1, 8, '{0, 5, 10, 5, 0, 5, 10, 5}};
`else
    vecs[7] = '{16'd0, 16'd10, 16'd5, 16'd1, 1'b1, 1'b1, 8, '{0, 5, 10, 0, 5, 10, 0, 5}};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Directed table
    foreach (vecs[i]) begin
      exp_q = {};
      for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].w[k]);
      check_sweep(vecs[i].s, vecs[i].e, vecs[i].st, vecs[i].dw, vecs[i].cont, vecs[i].abrt,
                  1'b0, 1'b0);
    end

    // start together with abort in IDLE: no sweep
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    bus_if.start_word = 16'd999;
    @(negedge clk);
    chk("start_abort_idle", last_tw, 1'b0, 1'b0, 1'b0);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle2", last_tw, 1'b0, 1'b0, 1'b0);

    // Back-to-back: new start on the edge right after done
    exp_q = {7, 9};
    check_sweep(16'd7, 16'd9, 16'd2, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q = {300, 290};
    check_sweep(16'd300, 16'd290, 16'd10, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Async reset between edges in mid-dwell
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.start_word = 16'd100;
    bus_if.stop_word  = 16'd130;
    bus_if.step_word  = 16'd10;
    bus_if.dwell      = 16'd5;
    bus_if.continuous = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("pre_reset_sweep", 16'd100, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #2 RST = 1'b1;
    #1 chk("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("held_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    exp_q = {100, 110, 120, 130};
    check_sweep(16'd100, 16'd130, 16'd10, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized sweeps against the reference model
    for (int it = 0; it < 30; it++) begin
      int  si, ei, sti, dwi, rng;
      bit  cont, abrt, fwd;
      rng = $urandom_range(0, 120);
      if (it % 5 == 0) begin
        si  = 65535 - $urandom_range(0, 40);
        ei  = 65535;
        sti = $urandom_range(1, 65535);
      end else begin
        si  = $urandom_range(0, 65535);
        ei  = ($urandom_range(0, 1) == 1) ? ((si + rng > 65535) ? 65535 : si + rng)
                                          : ((si - rng < 0) ? 0 : si - rng);
        sti = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 70);
      end
      dwi  = $urandom_range(0, 3);
      cont = ($urandom_range(0, 3) == 0) && (si != ei);
      abrt = cont || ($urandom_range(0, 3) == 0);
      build_leg(si, ei, sti);
      exp_q = leg_q;
      if (cont) begin
        fwd = 1'b0;
        while (exp_q.size() < 12) begin
`ifdef DDS_SWEEP_PINGPONG_EN
          if (fwd) build_leg(si, ei, sti);
          else     build_leg(ei, si, sti);
          for (int k = 1; k < leg_q.size(); k++) exp_q.push_back(leg_q[k]);
          fwd = !fwd;
`else
          for (int k = 0; k < leg_q.size(); k++) exp_q.push_back(leg_q[k]);
`endif
        end
        while (exp_q.size() > 12) void'(exp_q.pop_back());
      end else if (abrt) begin
        int keep;
        keep = $urandom_range(1, exp_q.size());
        while (exp_q.size() > keep) void'(exp_q.pop_back());
      end
      check_sweep(16'(si), 16'(ei), 16'(sti), 16'(dwi), cont, abrt, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer that drives the `tuning_word` input of the DDS top level. On a start request it latches a start word, stop word, step size and dwell count, then steps the tuning word from start toward stop, holding each value for a programmed number of clocks. It supports single-shot and continuous sweeps and provides a busy/done handshake to the system controller.

## Interface
- `TUNE_WIDTH`, 16, width of all tuning words; must match the DDS tuning input width.
- `DWELL_WIDTH`, 16, width of the dwell count.
- `clk`  in  1  system clock, rising-edge.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `abort`  in  1  stop the current sweep immediately; no `done`.
- `continuous`  in  1  latched at start; 1 = repeat sweep until abort.
- `start_word`  in  TUNE_WIDTH  first tuning word.
- `stop_word`  in  TUNE_WIDTH  final tuning word; direction = up if `stop_word >= start_word`, else down.
- `step_word`  in  TUNE_WIDTH  magnitude of the per-step increment; 0 treated as 1.
- `dwell`  in  DWELL_WIDTH  clocks each word is held; 0 treated as 1.
- `tuning_word`  out  TUNE_WIDTH  registered output to the DDS.
- `busy`  out  1  high while a sweep is active.
- `done`  out  1  one-cycle pulse when a single-shot sweep completes.
- `step_strobe`  out  1  one-cycle pulse on every cycle `tuning_word` is loaded with a new sweep value.

## Operation
- States: IDLE, DWELL, STEP.
- IDLE: `busy`=0. On `start`=1 and `abort`=0: latch all config inputs, load `tuning_word`=`start_word`, pulse `step_strobe`, load dwell counter, go DWELL. Config inputs are ignored outside IDLE.
- DWELL: count down max(dwell,1) cycles including the load cycle; on expiry go STEP.
- STEP (single cycle, combined with next load): if current word == stop → end-of-sweep; else next = current ± step; if next passes stop or the add/subtract carries/borrows out of TUNE_WIDTH bits, next = stop. Load next, pulse `step_strobe`, reload dwell, return to DWELL.
- End-of-sweep, single-shot: pulse `done`, drop `busy`, go IDLE; `tuning_word` holds stop value.
- End-of-sweep, continuous: behaviour per Configuration; `done` never pulses.
- `start_word == stop_word`: one dwell period at that word, then end-of-sweep.
- `abort` (any non-IDLE state): next cycle `busy`=0, IDLE, `tuning_word` holds its current value, no `done`, no `step_strobe`.
- `abort` and `start` together in IDLE: abort wins, start ignored.
- `start` while busy: ignored.
- Reset (any time, including mid-sweep): `tuning_word`=0, `busy`=0, `done`=0, `step_strobe`=0, state IDLE, counters cleared.

## Timing
- `start` sampled at edge N → `tuning_word`=start_word, `busy`=1, `step_strobe`=1 after edge N.
- Each word is valid for exactly max(dwell,1) cycles; transitions are back-to-back with no idle cycle.
- Single-shot with K words: `done`=1 and `busy`=0 after edge N + K·max(dwell,1).
- New `start` accepted on the edge after `done` (one IDLE cycle minimum between sweeps).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `DDS_SWEEP_PINGPONG_EN` defined: continuous sweeps reverse direction at each endpoint (triangle); the endpoint word is dwelled once, not twice; the reverse leg clamps at start_word.
- Not defined: continuous sweeps reload start_word after the stop word's dwell (sawtooth) with `step_strobe` pulsed.
- Single-shot behaviour is identical in both builds.

## Test plan
- Up sweep: start=100, stop=130, step=10, dwell=3 → words 100,110,120,130 each 3 cycles; `done` pulse 12 cycles after start edge; `tuning_word` stays 130.
- Overshoot/overflow clamp: start=0x0000, stop=0x0019, step=10, dwell=1 → 0,10,20,25; start=0xFFF0, stop=0xFFFF, step=0x0C → 0xFFF0,0xFFFC,0xFFFF.
- Down sweep and degenerate inputs: start=50, stop=20, step=15, dwell=0 → 50,35,20 one cycle each; step=0 with start=5, stop=7 → 5,6,7.
- Continuous: start=0, stop=10, step=5, dwell=1 → without macro 0,5,10,0,5,…; with `DDS_SWEEP_PINGPONG_EN` 0,5,10,5,0,5,…; `done` never asserts.
- Abort mid-sweep at word 110 (first test config) → next cycle `busy`=0, `tuning_word`=110, no `done`; simultaneous `start`+`abort` in IDLE → no sweep.
- Async `RST` asserted mid-dwell between edges → all outputs 0 immediately; after release, `start` behaves as from power-up.
